// File: rtl/layer_output_sequencer.sv
// Captures one layer's parallel result vector and replays it one word per beat, neuron 0 first.
// Optional SEQ_ERR_CHECK_EN adds a sticky error flag for overruns and out-of-step valids.
module layer_output_sequencer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           in_valid,
  input  logic [NN*dataWidth-1:0] in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [dataWidth-1:0]    out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    err
);

  localparam int IW = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NN - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                       r_state, w_state_nxt;
  logic [IW-1:0]                r_idx, w_idx_nxt;
  logic [NN-1:0][dataWidth-1:0] r_hold;
  logic                         w_capture, w_overrun, w_accept, w_last;

  assign w_accept = (r_state == S_SHIFT) && out_ready;
  assign w_last   = (r_idx == LAST_IDX);

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_capture   = 1'b0;
    w_overrun   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid[0]) begin
          w_capture   = 1'b1;
          w_idx_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_accept && w_last) begin
          w_idx_nxt = '0;
          if (in_valid[0]) w_capture   = 1'b1;  // back-to-back vector, no bubble
          else             w_state_nxt = S_IDLE;
        end else begin
          if (w_accept)    w_idx_nxt = r_idx + IW'(1);
          if (in_valid[0]) w_overrun = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update together on the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_capture) r_hold <= in_data;
    end
  end

  // Outputs decode registers only, so reset clears them without waiting for a clock.
  assign busy      = (r_state == S_SHIFT);
  assign out_valid = busy;
  assign out_data  = busy ? r_hold[r_idx] : '0;
  assign out_last  = busy && w_last;

`ifdef SEQ_ERR_CHECK_EN
  logic r_err;
  logic w_mismatch;

  assign w_mismatch = w_capture && !(&in_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         r_err <= 1'b0;
    else if (w_overrun || w_mismatch) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  logic w_unused_valid;
  logic w_unused_overrun;

  assign w_unused_valid   = &in_valid;
  assign w_unused_overrun = w_overrun;
  assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_layer_output_sequencer.sv
// Directed bench for layer_output_sequencer (NN=4, 16-bit words) with a beat scoreboard.
module tb_layer_output_sequencer;

  localparam int NN = 4;
  localparam int DW = 16;
`ifdef SEQ_ERR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [NN-1:0]    in_valid;
  logic [NN*DW-1:0] in_data;
  logic             out_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_last;
  logic             busy;
  logic             err;

  int total = 0;
  int bad   = 0;
  logic [DW:0] exp_q[$];  // {last, data}

  layer_output_sequencer #(.NN(NN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [NN*DW-1:0] v);
    for (int k = 0; k < NN; k++)
      exp_q.push_back({(k == NN - 1), v[k*DW +: DW]});
  endtask

  // Scoreboard: every accepted beat must match the next expected word.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {31'b0, out_valid}, 32'd0);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("beat_data", {16'b0, out_data}, {16'b0, e[DW-1:0]});
        check("beat_last", {31'b0, out_last}, {31'b0, e[DW]});
      end
    end
  end

  logic [NN*DW-1:0] vec_a, vec_b;

  initial begin
    vec_a     = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
    vec_b     = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    rst       = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;

    #2;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data",  {16'b0, out_data},  32'd0);
    check("rst_out_last",  {31'b0, out_last},  32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    check("rst_err",       {31'b0, err},       32'd0);
    tick();
    rst = 1'b1;
    tick();

    // 1: straight replay with out_ready held high.
    out_ready = 1'b1;
    in_valid  = 4'hF;
    in_data   = vec_a;
    push_vec(vec_a);
    tick();
    in_valid = '0;
    check("t1_w0_valid", {31'b0, out_valid}, 32'd1);
    check("t1_w0_data",  {16'b0, out_data},  32'h1);
    tick(); tick(); tick();
    check("t1_w3_data", {16'b0, out_data}, 32'h4);
    check("t1_w3_last", {31'b0, out_last}, 32'd1);
    tick();
    check("t1_idle_busy",  {31'b0, busy},      32'd0);
    check("t1_idle_valid", {31'b0, out_valid}, 32'd0);
    check("t1_q_empty", exp_q.size(), 32'd0);

    // 2: stall on word 2 for three cycles.
    in_valid = 4'hF;
    in_data  = vec_a;
    push_vec(vec_a);
    tick();
    in_valid = '0;
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("t2_stall_data",  {16'b0, out_data},  32'h2);
      check("t2_stall_valid", {31'b0, out_valid}, 32'd1);
      check("t2_stall_last",  {31'b0, out_last},  32'd0);
      tick();
    end
    out_ready = 1'b1;
    check("t2_resume_data", {16'b0, out_data}, 32'h2);
    tick();
    check("t2_w2_data", {16'b0, out_data}, 32'h3);
    tick(); tick();
    check("t2_idle_busy", {31'b0, busy}, 32'd0);
    check("t2_q_empty", exp_q.size(), 32'd0);

    // 3: next vector presented exactly on the last accept.
    in_valid = 4'hF;
    in_data  = vec_a;
    push_vec(vec_a);
    tick();
    in_valid = '0;
    tick(); tick(); tick();
    check("t3_last_word", {16'b0, out_data}, 32'h4);
    in_valid = 4'hF;
    in_data  = vec_b;
    push_vec(vec_b);
    tick();
    in_valid = '0;
    check("t3_b2b_valid", {31'b0, out_valid}, 32'd1);
    check("t3_b2b_data",  {16'b0, out_data},  32'hA);
    check("t3_b2b_last",  {31'b0, out_last},  32'd0);
    tick(); tick(); tick();
    check("t3_b_last_data", {16'b0, out_data}, 32'hD);
    tick();
    check("t3_idle_valid", {31'b0, out_valid}, 32'd0);
    check("t3_q_empty", exp_q.size(), 32'd0);
    check("t3_err_clear", {31'b0, err}, 32'd0);

    // 4: overrun while word 2 is presented is dropped.
    in_valid = 4'hF;
    in_data  = vec_a;
    push_vec(vec_a);
    tick();
    in_valid = '0;
    tick();
    in_valid = 4'hF;
    in_data  = vec_b;
    tick();
    in_valid = '0;
    check("t4_after_ovr_data", {16'b0, out_data}, 32'h3);
    check("t4_err", {31'b0, err}, {31'b0, ERR_EN});
    tick(); tick();
    check("t4_idle_busy", {31'b0, busy}, 32'd0);
    check("t4_err_sticky", {31'b0, err}, {31'b0, ERR_EN});
    check("t4_q_empty", exp_q.size(), 32'd0);

    // Clear the sticky flag before the mismatch case.
    rst = 1'b0;
    #1;
    check("t4_rst_err", {31'b0, err}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // 5: partial valid captures anyway; async reset during word 3.
    in_valid = 4'h1;
    in_data  = vec_a;
    push_vec(vec_a);
    tick();
    in_valid = '0;
    check("t5_w0_data", {16'b0, out_data}, 32'h1);
    check("t5_err", {31'b0, err}, {31'b0, ERR_EN});
    tick(); tick();
    check("t5_w2_data", {16'b0, out_data}, 32'h3);
    rst = 1'b0;
    #1;
    check("t5_arst_valid", {31'b0, out_valid}, 32'd0);
    check("t5_arst_data",  {16'b0, out_data},  32'd0);
    check("t5_arst_busy",  {31'b0, busy},      32'd0);
    check("t5_arst_err",   {31'b0, err},       32'd0);
    check("t5_arst_last",  {31'b0, out_last},  32'd0);
    check("t5_lost_words", exp_q.size(), 32'd2);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick(); tick();
    check("t5_stays_idle", {31'b0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
